// File: rtl/out_mix_pkg.sv
// Shared definitions for the out_mix_ser pixel serializer: register map,
// format-control bit positions, the formatted-pixel record and the
// per-pixel formatting rule applied when a beat is captured.
package out_mix_pkg;

  // Avalon-MM register addresses
  localparam logic [1:0] ADDR_FMT    = 2'd0;
  localparam logic [1:0] ADDR_BLANKC = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_BEATS  = 2'd3;

  // Bit positions inside the FMT register
  localparam int SWAP   = 0;
  localparam int HINV   = 1;
  localparam int VINV   = 2;
  localparam int BFILL  = 3;
  localparam int FBLANK = 4;

  localparam int FMT_W = 5;
  localparam int PIX_W = 24;

  // One pixel as it leaves the serializer
  typedef struct packed {
    logic             de;
    logic             h_sync;
    logic             v_sync;
    logic [PIX_W-1:0] data;
  } pix_t;

  // Formats one lane. Force-blank beats blank-fill, which beats the
  // optional c0/c2 swap. Sync polarity inversion applies in every case.
  function automatic pix_t format_pixel(
    input logic [PIX_W-1:0] px,
    input logic             de,
    input logic             hs,
    input logic             vs,
    input logic [FMT_W-1:0] fmt,
    input logic [PIX_W-1:0] blankc
  );
    pix_t p;
    p.h_sync = hs ^ fmt[HINV];
    p.v_sync = vs ^ fmt[VINV];
    if (fmt[FBLANK]) begin
      p.de   = 1'b0;
      p.data = blankc;
    end else if (fmt[BFILL] && !de) begin
      p.de   = 1'b0;
      p.data = blankc;
    end else begin
      p.de   = de;
      p.data = fmt[SWAP] ? {px[7:0], px[15:8], px[23:16]} : px;
    end
    return p;
  endfunction

endpackage

// File: rtl/out_mix_regs.sv
// Control/status register file for out_mix_ser: FMT and BLANKC storage,
// sticky underflow flag with saturating counter, free-running beat
// counter and registered read-back.
module out_mix_regs
  import out_mix_pkg::*;
#(
  parameter int UF_CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             capture,
  input  logic             underflow,
  input  logic [1:0]       control_address,
  input  logic             control_write,
  input  logic [31:0]      control_writedata,
  input  logic             control_read,
  output logic [31:0]      control_readdata,
  output logic [FMT_W-1:0] fmt,
  output logic [PIX_W-1:0] blankc
);

  logic                status_sel;
  logic                uf_event;
  logic                clr_sticky;
  logic                clr_count;
  logic                sticky;
  logic [UF_CNT_W-1:0] uf_count;
  logic [31:0]         beats;
  logic [31:0]         status_word;
  logic [31:0]         read_mux;
  logic                unused_wdata;

  assign unused_wdata = ^control_writedata[30:24];

  // Decode the write-side events that touch STATUS this cycle
  always_comb begin
    status_sel = control_write && (control_address == ADDR_STATUS);
    uf_event   = capture && underflow;
    clr_sticky = status_sel && control_writedata[0];
    clr_count  = status_sel && control_writedata[31];
  end

  // FMT and BLANKC are plain read/write storage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fmt    <= '0;
      blankc <= '0;
    end else if (control_write) begin
      if (control_address == ADDR_FMT)
        fmt <= control_writedata[FMT_W-1:0];
      if (control_address == ADDR_BLANKC)
        blankc <= control_writedata[PIX_W-1:0];
    end
  end

  // Sticky flag: a new underflow wins over a simultaneous clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      sticky <= 1'b0;
    else if (uf_event)
      sticky <= 1'b1;
    else if (clr_sticky)
      sticky <= 1'b0;
  end

  // Saturating underflow counter; clear plus increment on one edge yields 1
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      uf_count <= '0;
    end else if (uf_event) begin
      if (clr_count)
        uf_count <= UF_CNT_W'(1);
      else if (uf_count != {UF_CNT_W{1'b1}})
        uf_count <= uf_count + UF_CNT_W'(1);
    end else if (clr_count) begin
      uf_count <= '0;
    end
  end

  // Beat counter advances on every capture edge and wraps freely
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      beats <= '0;
    else if (capture)
      beats <= beats + 32'd1;
  end

  // Read-back multiplexer built from the current (pre-edge) register values
  always_comb begin
    status_word                 = '0;
    status_word[0]              = sticky;
    status_word[16 +: UF_CNT_W] = uf_count;
    read_mux = '0;
    case (control_address)
      ADDR_FMT:    read_mux = {{(32-FMT_W){1'b0}}, fmt};
      ADDR_BLANKC: read_mux = {{(32-PIX_W){1'b0}}, blankc};
      ADDR_STATUS: read_mux = status_word;
      ADDR_BEATS:  read_mux = beats;
      default:     read_mux = '0;
    endcase
  end

  // Read data is captured on a read strobe and held until the next read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      control_readdata <= '0;
    else if (control_read)
      control_readdata <= read_mux;
  end

endmodule

// File: rtl/out_mix_ser.sv
// Pixel serializer: divides clk into vid_clk, captures a multi-pixel beat
// once per vid_clk period, formats each lane and shifts the lanes out one
// pixel per clk, lane 0 first.
module out_mix_ser
  import out_mix_pkg::*;
#(
  parameter int PIX_PER_BEAT = 2,
  parameter int BPP          = 24,
  parameter int UF_CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  output logic                        vid_clk,
  input  logic [PIX_PER_BEAT-1:0]     vid_datavalid,
  input  logic [PIX_PER_BEAT-1:0]     vid_h_sync,
  input  logic [PIX_PER_BEAT-1:0]     vid_v_sync,
  input  logic [PIX_PER_BEAT*BPP-1:0] vid_data,
  input  logic                        underflow,
  input  logic [1:0]                  control_address,
  input  logic                        control_write,
  input  logic [31:0]                 control_writedata,
  input  logic                        control_read,
  output logic [31:0]                 control_readdata,
  output logic                        de,
  output logic                        h_sync,
  output logic                        v_sync,
  output logic [PIX_W-1:0]            data
);

  localparam int              PH_W    = (PIX_PER_BEAT > 1) ? $clog2(PIX_PER_BEAT) : 1;
  localparam int              HALF    = (PIX_PER_BEAT + 1) / 2;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PIX_PER_BEAT - 1);
  localparam logic [PH_W-1:0] PH_HALF = PH_W'(HALF);

  logic [PH_W-1:0]  ph;
  logic [PH_W-1:0]  ph_next;
  logic             started;
  logic             capture;
  logic             vid_clk_next;
  logic [FMT_W-1:0] fmt;
  logic [PIX_W-1:0] blankc;
  pix_t             lane_fmt [PIX_PER_BEAT];
  pix_t             shreg    [PIX_PER_BEAT-1];
  pix_t             out_pix;

  // Next phase; the very first edge after reset is forced to be a capture
  always_comb begin
    ph_next = '0;
    if (started && (ph != PH_LAST))
      ph_next = ph + PH_W'(1);
    capture      = (ph_next == '0);
    vid_clk_next = (ph_next < PH_HALF);
  end

  // Phase counter, start flag and the registered divided clock
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ph      <= '0;
      started <= 1'b0;
      vid_clk <= 1'b0;
    end else begin
      ph      <= ph_next;
      started <= 1'b1;
      vid_clk <= vid_clk_next;
    end
  end

  // Format every lane of the incoming beat with the current FMT/BLANKC
  always_comb begin
    for (int k = 0; k < PIX_PER_BEAT; k++) begin
      lane_fmt[k] = format_pixel(vid_data[k*BPP +: BPP], vid_datavalid[k],
                                 vid_h_sync[k], vid_v_sync[k], fmt, blankc);
    end
  end

  // Capture loads lane 0 to the outputs and parks the rest; otherwise shift
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_pix <= '0;
      for (int i = 0; i < PIX_PER_BEAT - 1; i++)
        shreg[i] <= '0;
    end else if (capture) begin
      out_pix <= lane_fmt[0];
      for (int i = 0; i < PIX_PER_BEAT - 1; i++)
        shreg[i] <= lane_fmt[i+1];
    end else begin
      out_pix <= shreg[0];
      for (int i = 0; i < PIX_PER_BEAT - 2; i++)
        shreg[i] <= shreg[i+1];
      shreg[PIX_PER_BEAT-2] <= '0;
    end
  end

  assign de     = out_pix.de;
  assign h_sync = out_pix.h_sync;
  assign v_sync = out_pix.v_sync;
  assign data   = out_pix.data;

  out_mix_regs #(
    .UF_CNT_W (UF_CNT_W)
  ) u_regs (
    .clk               (clk),
    .reset_n           (reset_n),
    .capture           (capture),
    .underflow         (underflow),
    .control_address   (control_address),
    .control_write     (control_write),
    .control_writedata (control_writedata),
    .control_read      (control_read),
    .control_readdata  (control_readdata),
    .fmt               (fmt),
    .blankc            (blankc)
  );

endmodule

// File: tb/tb_out_mix_ser.sv
// Bench for out_mix_ser: two instances (2 and 4 pixels per beat, the second
// with a 4-bit underflow counter) sharing clock, reset and control bus,
// checked every cycle against a beat/lane arithmetic model plus literals.
module tb_out_mix_ser;

  localparam int P0  = 2;
  localparam int P1  = 4;
  localparam int CW1 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [1:0]  caddr;
  logic        cwrite;
  logic        cread;
  logic [31:0] cwdata;

  logic [23:0] ldata [2][4];
  logic        lde   [2][4];
  logic        lhs   [2][4];
  logic        lvs   [2][4];
  logic        uf    [2];

  logic [P0*24-1:0] vd0;
  logic [P0-1:0]    de0_in, hs0_in, vs0_in;
  logic [P1*24-1:0] vd1;
  logic [P1-1:0]    de1_in, hs1_in, vs1_in;

  logic [1:0]  o_vclk, o_de, o_hs, o_vs;
  logic [23:0] o_data [2];
  logic [31:0] o_rd   [2];

  int n_cmp  = 0;
  int n_fail = 0;

  // Pack the per-lane stimulus arrays into the DUT bus layouts
  always_comb begin
    for (int k = 0; k < P0; k++) begin
      vd0[k*24 +: 24] = ldata[0][k];
      de0_in[k] = lde[0][k]; hs0_in[k] = lhs[0][k]; vs0_in[k] = lvs[0][k];
    end
    for (int k = 0; k < P1; k++) begin
      vd1[k*24 +: 24] = ldata[1][k];
      de1_in[k] = lde[1][k]; hs1_in[k] = lhs[1][k]; vs1_in[k] = lvs[1][k];
    end
  end

  out_mix_ser #(.PIX_PER_BEAT(P0), .BPP(24), .UF_CNT_W(16)) dut2 (
    .clk(clk), .reset_n(reset_n), .vid_clk(o_vclk[0]),
    .vid_datavalid(de0_in), .vid_h_sync(hs0_in), .vid_v_sync(vs0_in),
    .vid_data(vd0), .underflow(uf[0]),
    .control_address(caddr), .control_write(cwrite),
    .control_writedata(cwdata), .control_read(cread),
    .control_readdata(o_rd[0]),
    .de(o_de[0]), .h_sync(o_hs[0]), .v_sync(o_vs[0]), .data(o_data[0])
  );

  out_mix_ser #(.PIX_PER_BEAT(P1), .BPP(24), .UF_CNT_W(CW1)) dut4 (
    .clk(clk), .reset_n(reset_n), .vid_clk(o_vclk[1]),
    .vid_datavalid(de1_in), .vid_h_sync(hs1_in), .vid_v_sync(vs1_in),
    .vid_data(vd1), .underflow(uf[1]),
    .control_address(caddr), .control_write(cwrite),
    .control_writedata(cwdata), .control_read(cread),
    .control_readdata(o_rd[1]),
    .de(o_de[1]), .h_sync(o_hs[1]), .v_sync(o_vs[1]), .data(o_data[1])
  );

  // ---------------- model ----------------
  int          t       [2] = '{0, 0};
  int          lk      [2] = '{-1, -1};
  logic [26:0] capbuf  [2][4];
  logic [26:0] exp_pix [2] = '{27'd0, 27'd0};
  logic        exp_vclk[2] = '{1'b0, 1'b0};
  logic [31:0] exp_rd  [2] = '{32'd0, 32'd0};
  logic [4:0]  m_fmt    = '0;
  logic [23:0] m_blankc = '0;
  logic        m_sticky[2] = '{1'b0, 1'b0};
  int          m_cnt   [2] = '{0, 0};
  logic [31:0] m_beats [2] = '{32'd0, 32'd0};

  function automatic int pp(int d);
    return (d == 0) ? P0 : P1;
  endfunction

  function automatic int cmax(int d);
    return (d == 0) ? 65535 : (1 << CW1) - 1;
  endfunction

  function automatic logic [26:0] fmt_pix(logic [23:0] px, logic e, logic hs,
                                          logic vs, logic [4:0] f, logic [23:0] bc);
    logic [23:0] dd;
    logic        ee;
    if (f[4]) begin
      ee = 1'b0; dd = bc;
    end else if (f[3] && !e) begin
      ee = 1'b0; dd = bc;
    end else begin
      ee = e;
      dd = f[0] ? {px[7:0], px[15:8], px[23:16]} : px;
    end
    return {ee, hs ^ f[1], vs ^ f[2], dd};
  endfunction

  function automatic logic [31:0] m_read(int d, logic [1:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      2'd0: r = {27'd0, m_fmt};
      2'd1: r = {8'd0, m_blankc};
      2'd2: begin r[0] = m_sticky[d]; r[31:16] = m_cnt[d][15:0]; end
      default: r = m_beats[d];
    endcase
    return r;
  endfunction

  // Edge t after reset shows lane (t-1)%P of the beat sampled at its first edge
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int d = 0; d < 2; d++) begin
        t[d] = 0; lk[d] = -1; exp_pix[d] = '0; exp_vclk[d] = 1'b0;
        exp_rd[d] = '0; m_sticky[d] = 1'b0; m_cnt[d] = 0; m_beats[d] = '0;
        for (int l = 0; l < 4; l++) capbuf[d][l] = '0;
      end
      m_fmt = '0; m_blankc = '0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        int k;
        if (cread) exp_rd[d] = m_read(d, caddr);
        k = t[d] % pp(d);
        t[d]++;
        lk[d] = k;
        if (k == 0) begin
          for (int l = 0; l < pp(d); l++)
            capbuf[d][l] = fmt_pix(ldata[d][l], lde[d][l], lhs[d][l], lvs[d][l],
                                   m_fmt, m_blankc);
          m_beats[d] = m_beats[d] + 32'd1;
        end
        exp_pix[d]  = capbuf[d][k];
        exp_vclk[d] = (k < (pp(d) + 1) / 2);
        if (cwrite && caddr == 2'd2) begin
          if (cwdata[0])  m_sticky[d] = 1'b0;
          if (cwdata[31]) m_cnt[d] = 0;
        end
        if (k == 0 && uf[d]) begin
          m_sticky[d] = 1'b1;
          if (m_cnt[d] < cmax(d)) m_cnt[d]++;
        end
      end
      if (cwrite && caddr == 2'd0) m_fmt = cwdata[4:0];
      if (cwrite && caddr == 2'd1) m_blankc = cwdata[23:0];
    end
  end

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Compare both instances against the model every cycle, mid-low-phase
  always @(negedge clk) begin
    #2;
    for (int d = 0; d < 2; d++) begin
      string pre;
      pre = (d == 0) ? "p2" : "p4";
      if (!reset_n) begin
        checkOutput({pre, "_rst_data"}, {8'd0, o_data[d]}, 32'd0);
        checkOutput({pre, "_rst_de"}, {31'd0, o_de[d]}, 32'd0);
        checkOutput({pre, "_rst_vclk"}, {31'd0, o_vclk[d]}, 32'd0);
        checkOutput({pre, "_rst_rd"}, o_rd[d], 32'd0);
      end else begin
        checkOutput({pre, "_data"}, {8'd0, o_data[d]}, {8'd0, exp_pix[d][23:0]});
        checkOutput({pre, "_de"}, {31'd0, o_de[d]}, {31'd0, exp_pix[d][26]});
        checkOutput({pre, "_hs"}, {31'd0, o_hs[d]}, {31'd0, exp_pix[d][25]});
        checkOutput({pre, "_vs"}, {31'd0, o_vs[d]}, {31'd0, exp_pix[d][24]});
        checkOutput({pre, "_vclk"}, {31'd0, o_vclk[d]}, {31'd0, exp_vclk[d]});
        checkOutput({pre, "_rd"}, o_rd[d], exp_rd[d]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyStimulus(int d, int k, logic [23:0] px, logic e, logic hs, logic vs);
    ldata[d][k] = px; lde[d][k] = e; lhs[d][k] = hs; lvs[d][k] = vs;
  endtask

  task automatic write_reg(logic [1:0] a, logic [31:0] v);
    caddr = a; cwdata = v; cwrite = 1'b1;
    tick();
    cwrite = 1'b0;
  endtask

  task automatic read_reg(logic [1:0] a);
    caddr = a; cread = 1'b1;
    tick();
    cread = 1'b0;
  endtask

  task automatic wait_phase(int d, int k);
    int n;
    n = 0;
    while (lk[d] != k && n < 20) begin
      tick();
      n++;
    end
    checkOutput("wait_phase", lk[d], k);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset_n = 1'b1; cwrite = 1'b0; cread = 1'b0; caddr = '0; cwdata = '0;
    uf[0] = 1'b0; uf[1] = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 4; k++) applyStimulus(d, k, 24'd0, 1'b0, 1'b0, 1'b0);
    #1 reset_n = 1'b0;
    repeat (3) tick();
    checkOutput("reset_data_p2", {8'd0, o_data[0]}, 32'd0);
    checkOutput("reset_vclk_p2", {31'd0, o_vclk[0]}, 32'd0);
    checkOutput("reset_rd_p4", o_rd[1], 32'd0);

    applyStimulus(0, 0, 24'h112233, 1'b1, 1'b0, 1'b0);
    applyStimulus(0, 1, 24'h445566, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) applyStimulus(1, k, 24'hA0 + 24'(k), 1'b1, 1'b0, 1'b0);
    reset_n = 1'b1;

    // Basic serialisation and vid_clk shape for both beat widths
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("seq_data_p2", {8'd0, o_data[0]}, (i % 2 == 0) ? 32'h112233 : 32'h445566);
      checkOutput("seq_vclk_p2", {31'd0, o_vclk[0]}, (i % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput("seq_data_p4", {8'd0, o_data[1]}, 32'hA0 + 32'(i % 4));
      checkOutput("seq_vclk_p4", {31'd0, o_vclk[1]}, (i % 4 < 2) ? 32'd1 : 32'd0);
    end

    // Mid-beat FMT write takes effect from the next beat
    wait_phase(0, 0);
    caddr = 2'd0; cwdata = 32'd1; cwrite = 1'b1;
    tick();
    cwrite = 1'b0;
    checkOutput("fmt_midbeat_unswapped", {8'd0, o_data[0]}, 32'h445566);
    tick();
    checkOutput("fmt_swap_lane0", {8'd0, o_data[0]}, 32'h332211);
    tick();
    checkOutput("fmt_swap_lane1", {8'd0, o_data[0]}, 32'h665544);
    write_reg(2'd0, 32'd0);

    // Blank fill on a lane with de=0
    write_reg(2'd1, 32'h0000FF);
    write_reg(2'd0, 32'h08);
    applyStimulus(0, 1, 24'h777777, 1'b0, 1'b0, 1'b0);
    wait_phase(0, 1);
    tick();
    checkOutput("bfill_lane0_data", {8'd0, o_data[0]}, 32'h112233);
    checkOutput("bfill_lane0_de", {31'd0, o_de[0]}, 32'd1);
    tick();
    checkOutput("bfill_lane1_data", {8'd0, o_data[0]}, 32'h0000FF);
    checkOutput("bfill_lane1_de", {31'd0, o_de[0]}, 32'd0);

    // Force blank with syncs passing through
    applyStimulus(0, 0, 24'h112233, 1'b1, 1'b1, 1'b0);
    applyStimulus(0, 1, 24'h777777, 1'b0, 1'b0, 1'b1);
    write_reg(2'd0, 32'h10);
    wait_phase(0, 1);
    tick();
    checkOutput("fblank_data", {8'd0, o_data[0]}, 32'h0000FF);
    checkOutput("fblank_de", {31'd0, o_de[0]}, 32'd0);
    checkOutput("fblank_hs", {31'd0, o_hs[0]}, 32'd1);
    checkOutput("fblank_vs", {31'd0, o_vs[0]}, 32'd0);
    tick();
    checkOutput("fblank_l1_hs", {31'd0, o_hs[0]}, 32'd0);
    checkOutput("fblank_l1_vs", {31'd0, o_vs[0]}, 32'd1);

    // Sync inversion
    write_reg(2'd0, 32'h06);
    wait_phase(0, 1);
    tick();
    checkOutput("inv_hs", {31'd0, o_hs[0]}, 32'd0);
    checkOutput("inv_vs", {31'd0, o_vs[0]}, 32'd1);
    checkOutput("inv_data", {8'd0, o_data[0]}, 32'h112233);
    tick();
    checkOutput("inv_l1_hs", {31'd0, o_hs[0]}, 32'd1);
    checkOutput("inv_l1_data", {8'd0, o_data[0]}, 32'h777777);

    // Simultaneous read and write returns the old value
    caddr = 2'd0; cwdata = 32'd0; cwrite = 1'b1; cread = 1'b1;
    tick();
    cwrite = 1'b0; cread = 1'b0;
    checkOutput("rw_same_addr_old", o_rd[0], 32'h06);
    write_reg(2'd0, 32'hFFFFFFFF);
    read_reg(2'd0);
    checkOutput("fmt_readback_mask", o_rd[0], 32'h1F);
    write_reg(2'd0, 32'd0);
    read_reg(2'd1);
    checkOutput("blankc_readback", o_rd[0], 32'h0000FF);

    applyStimulus(0, 0, 24'h112233, 1'b1, 1'b0, 1'b0);
    applyStimulus(0, 1, 24'h445566, 1'b1, 1'b0, 1'b0);

    // Underflow over three capture edges
    wait_phase(0, 0);
    uf[0] = 1'b1;
    repeat (6) tick();
    uf[0] = 1'b0;
    read_reg(2'd2);
    checkOutput("status_3uf_p2", o_rd[0], 32'h00030001);
    checkOutput("status_none_p4", o_rd[1], 32'h0);

    // Clear coinciding with a fourth underflow capture
    wait_phase(0, 1);
    uf[0] = 1'b1; caddr = 2'd2; cwdata = 32'h80000001; cwrite = 1'b1;
    tick();
    uf[0] = 1'b0; cwrite = 1'b0;
    read_reg(2'd2);
    checkOutput("status_clr_vs_set", o_rd[0], 32'h00010001);

    // Saturation of the narrow counter
    uf[1] = 1'b1;
    repeat (80) tick();
    uf[1] = 1'b0;
    read_reg(2'd2);
    checkOutput("status_sat_p4", o_rd[1], 32'h000F0001);
    write_reg(2'd2, 32'h1);
    read_reg(2'd2);
    checkOutput("sticky_clr_p2", o_rd[0], 32'h00010000);
    checkOutput("sticky_clr_p4", o_rd[1], 32'h000F0000);

    // Asynchronous reset mid-beat
    wait_phase(0, 1);
    reset_n = 1'b0;
    #1;
    checkOutput("async_rst_data_p2", {8'd0, o_data[0]}, 32'd0);
    checkOutput("async_rst_data_p4", {8'd0, o_data[1]}, 32'd0);
    checkOutput("async_rst_de_p2", {31'd0, o_de[0]}, 32'd0);
    checkOutput("async_rst_rd_p2", o_rd[0], 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    checkOutput("post_rst_vclk_p2", {31'd0, o_vclk[0]}, 32'd1);
    checkOutput("post_rst_vclk_p4", {31'd0, o_vclk[1]}, 32'd1);
    checkOutput("post_rst_data_p2", {8'd0, o_data[0]}, 32'h112233);
    checkOutput("post_rst_data_p4", {8'd0, o_data[1]}, 32'hA0);
    read_reg(2'd3);
    checkOutput("beats_after_rst_p2", o_rd[0], 32'd1);
    checkOutput("beats_after_rst_p4", o_rd[1], 32'd1);

    repeat (4) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
